// File: rtl/vram_pkg.sv
// Shared framebuffer geometry, pixel type and arbiter enums.
// Used by the video controller and by the vram write arbiter.
package vram_pkg;

    localparam int WIDTH   = 1280;
    localparam int HEIGHT  = 720;
    localparam int TOT_PIX = WIDTH * HEIGHT;
    localparam int ADDR_W  = $clog2(TOT_PIX);
    localparam int DATA_W  = 24;

    // {R[23:16], G[15:8], B[7:0]}
    typedef logic [DATA_W-1:0] pixel_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } arb_state_t;

    typedef enum logic {
        REQ_HOST = 1'b0,
        REQ_DMA  = 1'b1
    } req_t;

    // True when a pixel address lands inside a framebuffer of the given depth.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned       depth);
        return {{(32-ADDR_W){1'b0}}, addr} < depth;
    endfunction

endpackage

// File: rtl/vram_wr_arbiter_if.sv
// Valid/ready pixel write channel from one requester into the arbiter.
interface vram_wr_arbiter_if;
    import vram_pkg::*;

    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    pixel_t            data;

    modport master (output valid, output addr, output data, input  ready);
    modport slave  (input  valid, input  addr, input  data, output ready);

endinterface

// File: rtl/vram_wr_arbiter_rr_arb2.sv
// Two-way round-robin grant between host and dma.
// Grant is combinational; only the last winner is registered so the
// loser of a contested cycle wins the next contest.
module rr_arb2
    import vram_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_host,
    input  logic req_dma,
    output logic gnt_host,
    output logic gnt_dma
);

    req_t last_q;

    // Grant the sole requester, or the one that did not win last time.
    always_comb begin
        gnt_host = 1'b0;
        gnt_dma  = 1'b0;
        if (en) begin
            if (req_host && req_dma) begin
                gnt_host = (last_q == REQ_DMA);
                gnt_dma  = (last_q == REQ_HOST);
            end else begin
                gnt_host = req_host;
                gnt_dma  = req_dma;
            end
        end
    end

    // Remember the winner of every transfer; reset favours host first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= REQ_DMA;
        end else if (gnt_host) begin
            last_q <= REQ_HOST;
        end else if (gnt_dma) begin
            last_q <= REQ_DMA;
        end
    end

endmodule

// File: rtl/vram_wr_arbiter.sv
// vram write-port arbiter: host and dma share the framebuffer write port,
// and an internal fill engine can clear the whole frame to one colour
// starting at a frame boundary.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | arbitrating host/dma; a pending fill waits here for sof
//   FILL  | one fill write per cycle, requesters held off
//
// FB_DEPTH defaults to the full 1280x720 frame; the address bus stays
// ADDR_W wide regardless.
module vram_wr_arbiter
    import vram_pkg::*;
#(
    parameter int unsigned FB_DEPTH = TOT_PIX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sof,
    vram_wr_arbiter_if.slave  host,
    vram_wr_arbiter_if.slave  dma,
    input  logic              fill_start,
    input  pixel_t            fill_color,
    output logic              fill_busy,
    output logic              fill_done,
    input  logic              err_clr,
    output logic              err_oob,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output pixel_t            wdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    arb_state_t        state;
    logic [ADDR_W-1:0] fill_cnt;
    pixel_t            fill_color_q;
    logic              fill_pending;

    logic              gnt_host;
    logic              gnt_dma;
    logic              xfer;
    logic              xfer_oob;
    logic [ADDR_W-1:0] xfer_addr;
    pixel_t            xfer_data;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .en       (state == IDLE),
        .req_host (host.valid),
        .req_dma  (dma.valid),
        .gnt_host (gnt_host),
        .gnt_dma  (gnt_dma)
    );

    assign host.ready = gnt_host;
    assign dma.ready  = gnt_dma;

    // Select the winning requester's write and flag it if it falls off the frame.
    always_comb begin
        xfer      = gnt_host | gnt_dma;
        xfer_addr = gnt_dma ? dma.addr : host.addr;
        xfer_data = gnt_dma ? dma.data : host.data;
        xfer_oob  = xfer && !addr_in_range(xfer_addr, FB_DEPTH);
    end

    // Sticky out-of-range flag; a new drop in the clearing cycle keeps it set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_oob <= 1'b0;
        end else if (xfer_oob) begin
            err_oob <= 1'b1;
        end else if (err_clr) begin
            err_oob <= 1'b0;
        end
    end

    // Main FSM: registered write port, fill scheduling and fill sequencing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            fill_cnt     <= '0;
            fill_color_q <= '0;
            fill_pending <= 1'b0;
            fill_busy    <= 1'b0;
            fill_done    <= 1'b0;
            we           <= 1'b0;
            waddr        <= '0;
            wdata        <= '0;
        end else begin
            we        <= 1'b0;
            fill_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer && !xfer_oob) begin
                        we    <= 1'b1;
                        waddr <= xfer_addr;
                        wdata <= xfer_data;
                    end
                    // busy covers both "pending" and "about to fill"; it
                    // falls the cycle after fill_done since pending is clear.
                    fill_busy <= fill_pending | fill_start;
                    if (fill_pending && sof) begin
                        state        <= FILL;
                        fill_cnt     <= '0;
                        fill_pending <= 1'b0;
                    end else if (fill_start) begin
                        // A fill_start arriving with sof only arms the fill,
                        // so it waits for the next frame boundary.
                        fill_pending <= 1'b1;
                        fill_color_q <= fill_color;
                    end
                end
                FILL: begin
                    we    <= 1'b1;
                    waddr <= fill_cnt;
                    wdata <= fill_color_q;
                    if (fill_cnt == LAST_ADDR) begin
                        fill_done <= 1'b1;
                        fill_cnt  <= '0;
                        state     <= IDLE;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_wr_arbiter.sv
// Directed bench for vram_wr_arbiter. The framebuffer depth is shrunk to
// keep each full-frame fill short; all addressing and compare logic is the
// same as at full size.
module tb_vram_wr_arbiter;
    import vram_pkg::*;

    localparam int DEPTH = 2048;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              sof = 1'b0;
    logic              fill_start = 1'b0;
    pixel_t            fill_color = '0;
    logic              err_clr = 1'b0;
    logic              fill_busy;
    logic              fill_done;
    logic              err_oob;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    pixel_t            wdata;

    int n_tests = 0;
    int n_fail  = 0;

    vram_wr_arbiter_if host_bus ();
    vram_wr_arbiter_if dma_bus ();

    vram_wr_arbiter #(.FB_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .sof        (sof),
        .host       (host_bus),
        .dma        (dma_bus),
        .fill_start (fill_start),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .err_clr    (err_clr),
        .err_oob    (err_oob),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_drive(input logic v, input int a, input pixel_t d);
        host_bus.valid = v;
        host_bus.addr  = ADDR_W'(a);
        host_bus.data  = d;
    endtask

    task automatic dma_drive(input logic v, input int a, input pixel_t d);
        dma_bus.valid = v;
        dma_bus.addr  = ADDR_W'(a);
        dma_bus.data  = d;
    endtask

    task automatic test_reset();
        host_drive(1'b0, 0, '0);
        dma_drive(1'b0, 0, '0);
        rst = 1'b0;
        repeat (3) step();
        n_tests++;
        if ({we, fill_busy, fill_done, err_oob} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: we/busy/done/oob=%b want 0000",
                     {we, fill_busy, fill_done, err_oob});
        end
        n_tests++;
        if (waddr !== '0 || wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: waddr=%0d wdata=%h want 0/0", waddr, wdata);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_rr_alternate();
        int hi = 0;
        int di = 0;
        logic exp_h;
        int exp_a;
        pixel_t exp_d;
        for (int c = 0; c < 4; c++) begin
            host_drive(1'b1, 10 + hi, 24'hA00000 + pixel_t'(10 + hi));
            dma_drive(1'b1, 20 + di, 24'h0B0000 + pixel_t'(20 + di));
            #1;
            exp_h = (c % 2 == 0);
            n_tests++;
            if ({host_bus.ready, dma_bus.ready} !== {exp_h, ~exp_h}) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: host/dma ready=%b want %b",
                         c, {host_bus.ready, dma_bus.ready}, {exp_h, ~exp_h});
            end
            exp_a = exp_h ? 10 + hi : 20 + di;
            exp_d = exp_h ? 24'hA00000 + pixel_t'(exp_a) : 24'h0B0000 + pixel_t'(exp_a);
            step();
            n_tests++;
            if (we !== 1'b1 || waddr !== ADDR_W'(exp_a) || wdata !== exp_d) begin
                n_fail++;
                $display("FAIL rr_write[%0d]: we=%b addr=%0d data=%h want 1/%0d/%h",
                         c, we, waddr, wdata, exp_a, exp_d);
            end
            if (exp_h) hi++;
            else       di++;
        end
        host_drive(1'b0, 0, '0);
        dma_drive(1'b0, 0, '0);
        step();
        n_tests++;
        if (we !== 1'b0 || waddr !== ADDR_W'(21) || wdata !== 24'h0B0015) begin
            n_fail++;
            $display("FAIL rr_hold: we=%b addr=%0d data=%h want 0/21/0b0015", we, waddr, wdata);
        end
    endtask

    task automatic test_host_write();
        host_drive(1'b1, 5, 24'hFF0000);
        #1;
        n_tests++;
        if (host_bus.ready !== 1'b1 || dma_bus.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL host_ready: host=%b dma=%b want 1/0", host_bus.ready, dma_bus.ready);
        end
        step();
        host_drive(1'b0, 0, '0);
        n_tests++;
        if (we !== 1'b1 || waddr !== ADDR_W'(5) || wdata !== 24'hFF0000) begin
            n_fail++;
            $display("FAIL host_write: we=%b addr=%0d data=%h want 1/5/ff0000", we, waddr, wdata);
        end
    endtask

    task automatic test_oob();
        host_drive(1'b1, 921600, 24'h123456);
        #1;
        n_tests++;
        if (host_bus.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_ready: ready=%b want 1", host_bus.ready);
        end
        step();
        host_drive(1'b0, 0, '0);
        n_tests++;
        if (we !== 1'b0 || err_oob !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_drop: we=%b err_oob=%b want 0/1", we, err_oob);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_tests++;
        if (err_oob !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_clear: err_oob=%b want 0", err_oob);
        end
        host_drive(1'b1, DEPTH, 24'h654321);
        err_clr = 1'b1;
        step();
        host_drive(1'b0, 0, '0);
        err_clr = 1'b0;
        n_tests++;
        if (we !== 1'b0 || err_oob !== 1'b1) begin
            n_fail++;
            $display("FAIL oob_set_wins: we=%b err_oob=%b want 0/1", we, err_oob);
        end
        host_drive(1'b1, DEPTH - 1, 24'h0000AA);
        step();
        host_drive(1'b0, 0, '0);
        n_tests++;
        if (we !== 1'b1 || waddr !== ADDR_W'(DEPTH - 1) || wdata !== 24'h0000AA) begin
            n_fail++;
            $display("FAIL oob_last_in_range: we=%b addr=%0d data=%h want 1/%0d/0000aa",
                     we, waddr, wdata, DEPTH - 1);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic test_fill();
        int bad = 0;
        int bad_i = -1;
        fill_start = 1'b1;
        fill_color = 24'h00FF00;
        sof = 1'b1;
        step();
        fill_start = 1'b0;
        fill_color = '0;
        sof = 1'b0;
        n_tests++;
        if (fill_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_busy_early: fill_busy=%b want 1", fill_busy);
        end
        repeat (49) step();
        n_tests++;
        if (we !== 1'b0 || fill_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_sof_with_start: we=%b busy=%b want 0/1", we, fill_busy);
        end
        host_drive(1'b1, 7, 24'h777777);
        sof = 1'b1;
        #1;
        n_tests++;
        if (host_bus.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_sof_xfer_ready: ready=%b want 1", host_bus.ready);
        end
        step();
        sof = 1'b0;
        n_tests++;
        if (we !== 1'b1 || waddr !== ADDR_W'(7) || host_bus.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_entry: we=%b addr=%0d ready=%b want 1/7/0", we, waddr, host_bus.ready);
        end
        for (int i = 0; i < DEPTH; i++) begin
            step();
            if (we !== 1'b1 || waddr !== ADDR_W'(i) || wdata !== 24'h00FF00 ||
                fill_busy !== 1'b1 || fill_done !== (i == DEPTH - 1) ||
                host_bus.ready !== (i == DEPTH - 1)) begin
                if (bad == 0) bad_i = i;
                bad++;
            end
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL fill_sweep: %0d bad cycles, first at %0d, want 0", bad, bad_i);
        end
        step();
        host_drive(1'b0, 0, '0);
        n_tests++;
        if (fill_busy !== 1'b0 || fill_done !== 1'b0 || we !== 1'b1 || waddr !== ADDR_W'(7)) begin
            n_fail++;
            $display("FAIL fill_exit: busy=%b done=%b we=%b addr=%0d want 0/0/1/7",
                     fill_busy, fill_done, we, waddr);
        end
    endtask

    task automatic test_fill_relatch();
        int bad = 0;
        int bad_i = -1;
        fill_start = 1'b1;
        fill_color = 24'h111111;
        step();
        fill_color = 24'h222222;
        step();
        fill_start = 1'b0;
        fill_color = '0;
        repeat (3) step();
        sof = 1'b1;
        step();
        sof = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            if (we !== 1'b1 || waddr !== ADDR_W'(i) || wdata !== 24'h222222 ||
                fill_done !== (i == DEPTH - 1)) begin
                if (bad == 0) bad_i = i;
                bad++;
            end
            sof        = (i == 100);
            fill_start = (i == 200);
            fill_color = (i == 200) ? 24'h333333 : 24'h000000;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL relatch_sweep: %0d bad cycles, first at %0d, want 0", bad, bad_i);
        end
        step();
        n_tests++;
        if (fill_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL relatch_start_in_fill: busy=%b want 0", fill_busy);
        end
        repeat (3) step();
        n_tests++;
        if (we !== 1'b0) begin
            n_fail++;
            $display("FAIL relatch_no_restart: we=%b want 0", we);
        end
    endtask

    task automatic test_reset_mid_fill();
        fill_start = 1'b1;
        fill_color = 24'hABCDEF;
        step();
        fill_start = 1'b0;
        sof = 1'b1;
        step();
        sof = 1'b0;
        repeat (1001) step();
        n_tests++;
        if (we !== 1'b1 || waddr !== ADDR_W'(1000) || wdata !== 24'hABCDEF) begin
            n_fail++;
            $display("FAIL midfill_pos: we=%b addr=%0d data=%h want 1/1000/abcdef", we, waddr, wdata);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (we !== 1'b0 || fill_busy !== 1'b0 || waddr !== '0) begin
            n_fail++;
            $display("FAIL midfill_abort: we=%b busy=%b addr=%0d want 0/0/0", we, fill_busy, waddr);
        end
        step();
        rst = 1'b1;
        step();
        host_drive(1'b1, 0, 24'h123456);
        #1;
        n_tests++;
        if (host_bus.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_ready: ready=%b want 1", host_bus.ready);
        end
        step();
        host_drive(1'b0, 0, '0);
        n_tests++;
        if (we !== 1'b1 || waddr !== '0 || wdata !== 24'h123456) begin
            n_fail++;
            $display("FAIL post_reset_write: we=%b addr=%0d data=%h want 1/0/123456", we, waddr, wdata);
        end
        step();
        n_tests++;
        if (we !== 1'b0 || fill_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: we=%b busy=%b want 0/0", we, fill_busy);
        end
    endtask

    initial begin
        test_reset();
        test_rr_alternate();
        test_host_write();
        test_oob();
        test_fill();
        test_fill_relatch();
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
